// File: rtl/sayuru_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sayuru_port_arbiter
// Purpose  : Round-robin two-master arbiter in front of the Sayuru cache input
//            port. One transaction in flight, per-master grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module sayuru_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // master 0
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  // master 1
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  // cache side
  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  // statistics
  output logic [31:0]             m0_grant_count,
  output logic [31:0]             m1_grant_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RV = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    owner_q;
  logic                    last_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [31:0]             m0_cnt_q;
  logic [31:0]             m1_cnt_q;

  logic                    pick_m1_d;
  logic                    in_req;
  logic                    in_wait;

  // On a tie the master that was not granted last wins.
  assign pick_m1_d = m1_req_i & (~m0_req_i | ~last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      m0_cnt_q <= 32'd0;
      m1_cnt_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            owner_q <= pick_m1_d;
            addr_q  <= pick_m1_d ? m1_addr_i  : m0_addr_i;
            we_q    <= pick_m1_d ? m1_we_i    : m0_we_i;
            be_q    <= pick_m1_d ? m1_be_i    : m0_be_i;
            wdata_q <= pick_m1_d ? m1_wdata_i : m0_wdata_i;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (s_gnt_i) begin
            if (owner_q) m1_cnt_q <= m1_cnt_q + 32'd1;
            else         m0_cnt_q <= m0_cnt_q + 32'd1;
            last_q  <= owner_q;
            state_q <= WAIT_RV;
          end
        end
        WAIT_RV: begin
          if (s_rvalid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_req  = (state_q == REQ);
  assign in_wait = (state_q == WAIT_RV);

  assign s_req_o     = in_req;
  assign s_addr_o    = addr_q;
  assign s_we_o      = we_q;
  assign s_be_o      = be_q;
  assign s_wdata_o   = wdata_q;

  // Grant and response are zero-latency pass-throughs steered to the owner.
  assign m0_gnt_o    = in_req  & s_gnt_i    & ~owner_q;
  assign m1_gnt_o    = in_req  & s_gnt_i    &  owner_q;
  assign m0_rvalid_o = in_wait & s_rvalid_i & ~owner_q;
  assign m1_rvalid_o = in_wait & s_rvalid_i &  owner_q;

  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  assign m0_grant_count = m0_cnt_q;
  assign m1_grant_count = m1_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sayuru_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sayuru_port_arbiter
// Purpose  : Directed and random checks of the arbiter against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sayuru_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wdata, m1_wdata, s_rdata;
  logic        s_gnt, s_rvalid;

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we;
  logic [15:0] s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic [31:0] m0_cnt, m1_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: one transaction record plus arbitration history
  bit          md_busy;
  bit          md_granted;
  bit          md_owner;
  bit          md_last;
  logic [52:0] md_txn;
  logic [31:0] md_cnt [2];

  always #5 clk = ~clk;

  sayuru_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
    .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_rdata_i(s_rdata),
    .m0_grant_count(m0_cnt), .m1_grant_count(m1_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_be = '0; m1_be = '0;
    m0_wdata = '0; m1_wdata = '0; s_rdata = '0; s_gnt = 0; s_rvalid = 0;
  endtask

  task automatic model_reset();
    md_busy = 0; md_granted = 0; md_owner = 0; md_last = 1;
    md_txn = '0; md_cnt[0] = 32'd0; md_cnt[1] = 32'd0;
  endtask

  // Called at a falling edge with inputs already applied: check, advance model.
  task automatic cyc();
    bit exp_req, w, r0, r1;
    #1;
    exp_req = md_busy && !md_granted;
    check("s_req",     s_req,     exp_req);
    check("m0_gnt",    m0_gnt,    exp_req && s_gnt && !md_owner);
    check("m1_gnt",    m1_gnt,    exp_req && s_gnt &&  md_owner);
    check("m0_rvalid", m0_rvalid, md_granted && s_rvalid && !md_owner);
    check("m1_rvalid", m1_rvalid, md_granted && s_rvalid &&  md_owner);
    check("s_txn",     {s_addr, s_we, s_be, s_wdata}, md_txn);
    check("m0_rdata",  m0_rdata,  s_rdata);
    check("m1_rdata",  m1_rdata,  s_rdata);
    check("m0_cnt",    m0_cnt,    md_cnt[0]);
    check("m1_cnt",    m1_cnt,    md_cnt[1]);
    r0 = m0_req; r1 = m1_req;
    if (!md_busy) begin
      if (r0 || r1) begin
        w = (r0 && r1) ? !md_last : r1;
        md_owner = w;
        md_txn = w ? {m1_addr, m1_we, m1_be, m1_wdata} : {m0_addr, m0_we, m0_be, m0_wdata};
        md_busy = 1; md_granted = 0;
      end
    end else if (!md_granted) begin
      if (s_gnt) begin
        md_cnt[md_owner] = md_cnt[md_owner] + 32'd1;
        md_last = md_owner;
        md_granted = 1;
      end
    end else if (s_rvalid) begin
      md_busy = 0; md_granted = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_s_req", s_req, 0);
    check("rst_gnt",   {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
    check("rst_s_txn", {s_addr, s_we, s_be, s_wdata}, 0);
    check("rst_cnt",   {m0_cnt, m1_cnt}, 0);
    @(negedge clk);
    rst = 0;
  endtask

  // Complete whatever is in flight with an immediately responsive cache.
  task automatic drain();
    int k;
    clear_inputs();
    s_gnt = 1; s_rvalid = 1;
    k = 0;
    while (md_busy && k < 8) begin
      cyc();
      k++;
    end
    check("drain_timeout", md_busy, 0);
    clear_inputs();
  endtask

  initial begin
    int order[$];
    int k;
    rst = 0;
    clear_inputs();
    model_reset();
    do_reset();

    // single m0 read, slow cache
    m0_req = 1; m0_addr = 16'h0040; m0_we = 0;
    cyc();
    m0_req = 0; m0_addr = 16'h7777;
    cyc(); cyc();
    s_gnt = 1;
    #1;
    check("t1_m0_gnt", m0_gnt, 1);
    check("t1_m1_gnt", m1_gnt, 0);
    check("t1_addr",   s_addr, 16'h0040);
    check("t1_we",     s_we, 0);
    cyc();
    s_gnt = 0;
    cyc(); cyc();
    s_rvalid = 1; s_rdata = 32'hDEADBEEF;
    #1;
    check("t1_m0_rvalid", m0_rvalid, 1);
    check("t1_m1_rvalid", m1_rvalid, 0);
    check("t1_rdata",     m0_rdata, 32'hDEADBEEF);
    cyc();
    clear_inputs();
    #1;
    check("t1_cnt0", m0_cnt, 32'd1);
    check("t1_cnt1", m1_cnt, 32'd0);
    cyc();

    // m1 write, address wiggles while the transaction is latched
    m1_req = 1; m1_addr = 16'h1234; m1_we = 1; m1_be = 4'b0011; m1_wdata = 32'h0000CAFE;
    cyc();
    m1_addr = 16'hABCD; m1_be = 4'b1100; m1_wdata = 32'h12345678; m1_we = 0;
    cyc();
    #1;
    check("t3_addr",  s_addr,  16'h1234);
    check("t3_be",    s_be,    4'b0011);
    check("t3_wdata", s_wdata, 32'h0000CAFE);
    check("t3_we",    s_we,    1);
    m1_req = 0;
    drain();
    cyc();

    // stray cache handshakes in the wrong states
    s_gnt = 1;
    cyc();
    s_gnt = 0; m0_req = 1; m0_addr = 16'h0100;
    cyc();
    m0_req = 0; s_rvalid = 1;
    cyc();
    s_rvalid = 0;
    #1;
    check("stray_cnt0", m0_cnt, 32'd1);
    check("stray_cnt1", m1_cnt, 32'd1);
    drain();
    cyc();

    // both masters request continuously from reset
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 16'h00A0; m1_addr = 16'h00B1;
    s_gnt = 1; s_rvalid = 1;
    k = 0;
    while (order.size() < 4 && k < 40) begin
      #1;
      if (m0_gnt) order.push_back(0);
      if (m1_gnt) order.push_back(1);
      cyc();
      k++;
    end
    check("rr_timeout", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++)
      check("rr_order", order[i], i % 2);
    #1;
    check("rr_cnt0", m0_cnt, 32'd2);
    check("rr_cnt1", m1_cnt, 32'd2);
    drain();
    cyc();

    // reset while waiting for the response
    m0_req = 1; m0_addr = 16'h0222;
    cyc();
    m0_req = 0; s_gnt = 1;
    cyc();
    s_gnt = 0;
    #2 rst = 1;
    #1;
    check("mid_s_req", s_req, 0);
    check("mid_cnt0",  m0_cnt, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    s_rvalid = 1;
    cyc();
    s_rvalid = 0;
    m0_req = 1; m1_req = 1; m0_addr = 16'h0AAA; m1_addr = 16'h0BBB;
    cyc();
    m0_req = 0; m1_req = 0;
    #1;
    check("mid_tie_addr", s_addr, 16'h0AAA);
    drain();
    cyc();

    // randomized traffic including stray handshakes
    for (int i = 0; i < 1500; i++) begin
      m0_req   = ($urandom % 3) != 0;
      m1_req   = ($urandom % 3) != 0;
      m0_addr  = 16'($urandom); m1_addr = 16'($urandom);
      m0_we    = 1'($urandom);  m1_we   = 1'($urandom);
      m0_be    = 4'($urandom);  m1_be   = 4'($urandom);
      m0_wdata = $urandom;      m1_wdata = $urandom;
      s_gnt    = ($urandom % 3) == 0;
      s_rvalid = ($urandom % 3) == 0;
      s_rdata  = $urandom;
      cyc();
    end
    drain();
    cyc();

    // counter wrap
    force dut.m0_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.m0_cnt_q;
    md_cnt[0] = 32'hFFFF_FFFF;
    m0_req = 1;
    cyc();
    m0_req = 0; s_gnt = 1;
    cyc();
    s_gnt = 0;
    #1;
    check("wrap_cnt0", m0_cnt, 32'd0);
    drain();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
